// File: rtl/i2c_bit_ctrl_pkg.sv
// i2c_pkg: shared command encodings, state enum and bus-level table for i2c_bit_ctrl
//   CMD_*    : 2-bit command codes carried on Cmd
//   PH_*     : phase index A..D, held in the low two state bits
//   state_t  : IDLE plus {1'b1, cmd, phase} for the 16 command/phase states
//   phase_levels(): {scl, sda} release pattern for a command in a given phase
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;

    localparam logic [1:0] PH_A = 2'd0;
    localparam logic [1:0] PH_B = 2'd1;
    localparam logic [1:0] PH_C = 2'd2;
    localparam logic [1:0] PH_D = 2'd3;

    typedef enum logic [4:0] {
        IDLE    = 5'b0_00_00,
        START_A = 5'b1_00_00, START_B = 5'b1_00_01, START_C = 5'b1_00_10, START_D = 5'b1_00_11,
        STOP_A  = 5'b1_01_00, STOP_B  = 5'b1_01_01, STOP_C  = 5'b1_01_10, STOP_D  = 5'b1_01_11,
        WR_A    = 5'b1_10_00, WR_B    = 5'b1_10_01, WR_C    = 5'b1_10_10, WR_D    = 5'b1_10_11,
        RD_A    = 5'b1_11_00, RD_B    = 5'b1_11_01, RD_C    = 5'b1_11_10, RD_D    = 5'b1_11_11
    } state_t;

    // START: SDA drops in C while SCL high; STOP: SDA rises in D while SCL high;
    // data bits: SCL high in B and C, SDA steady for the whole bit.
    function automatic logic [1:0] phase_levels(input logic [1:0] cmd, input logic [1:0] ph,
                                                 input logic din);
        logic scl_bit;
        scl_bit = (ph == PH_B) || (ph == PH_C);
        return cmd == CMD_START ? {ph != PH_D, ~ph[1]} :
               cmd == CMD_STOP  ? {ph != PH_A, ph == PH_D} :
               cmd == CMD_WRITE ? {scl_bit, din} : {scl_bit, 1'b1};
    endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// i2c_bit_ctrl_if: command, timer and open-drain bus bundle for i2c_bit_ctrl
//   Cmd/CmdValid/CmdReady/Din : command request handshake, Dout/Done : result
//   TimerOut/TimerStart/TimerStop : link to i2c_bit_timer
//   SclIn/SdaIn : bus levels, SclOen/SdaOen : open-drain enables (1 = released)
//   slave modport : the bit controller side, master modport : the driving side
interface i2c_bit_ctrl_if;

    logic [1:0] Cmd;
    logic       CmdValid;
    logic       CmdReady;
    logic       Din;
    logic       Dout;
    logic       Done;
    logic       TimerOut;
    logic       TimerStart;
    logic       TimerStop;
    logic       SclIn;
    logic       SdaIn;
    logic       SclOen;
    logic       SdaOen;

    modport slave (
        input  Cmd, CmdValid, Din, TimerOut, SclIn, SdaIn,
        output CmdReady, Dout, Done, TimerStart, TimerStop, SclOen, SdaOen
    );

    modport master (
        output Cmd, CmdValid, Din, TimerOut, SclIn, SdaIn,
        input  CmdReady, Dout, Done, TimerStart, TimerStop, SclOen, SdaOen
    );

endinterface

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: I2C bit-level sequencer driving START/STOP/WRITE/READ as four timer-paced phases
//   Clk : system clock, rising edge    Rst : synchronous active-high reset
//   bus : i2c_bit_ctrl_if.slave (command handshake, timer link, open-drain SCL/SDA)
//   Optional clock stretching when I2C_STRETCH_EN is defined: a phase B whose SCL is
//   released but still reads low freezes the timer and the phase until SCL goes high.
module i2c_bit_ctrl
    import i2c_pkg::*;
(
    input logic           Clk,
    input logic           Rst,
    i2c_bit_ctrl_if.slave bus
);

    state_t     r_state;
    state_t     w_next;
    logic       r_din;
    logic       r_scl_oen;
    logic       r_sda_oen;
    logic       r_dout;
    logic       r_done;
    logic       w_idle;
    logic       w_tick;
    logic       w_stretch;
    logic       w_din;
    logic       w_done;
    logic       w_sample;
    logic [1:0] w_levels;

    assign w_idle = r_state == IDLE;

`ifdef I2C_STRETCH_EN
    assign w_stretch = r_state[4] && (r_state[1:0] == PH_B) && r_scl_oen && !bus.SclIn;
`else
    logic w_unused_scl;
    assign w_unused_scl = bus.SclIn;
    assign w_stretch    = 1'b0;
`endif

    // TimerOut only advances a phase once a command is running, so a pulse
    // arriving in the accept cycle is dropped.
    assign w_tick = !w_idle && bus.TimerOut && !w_stretch;

    always_ff @(posedge Clk) begin
        if (Rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_idle)
            w_next = bus.CmdValid ? state_t'({1'b1, bus.Cmd, PH_A}) : IDLE;
        else if (w_tick)
            w_next = (r_state[1:0] == PH_D) ? IDLE : state_t'(r_state + 5'd1);
    end

    // Bus levels are looked up for the state being entered and then registered,
    // so SclOen/SdaOen change together with the state.
    always_comb begin
        w_din    = w_idle ? bus.Din : r_din;
        w_levels = phase_levels(w_next[3:2], w_next[1:0], w_din);
        w_done   = w_tick && (r_state[1:0] == PH_D);
        w_sample = w_tick && (r_state == RD_C);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_din     <= 1'b0;
            r_scl_oen <= 1'b1;
            r_sda_oen <= 1'b1;
            r_dout    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_din  <= w_din;
            r_done <= w_done;
            if (w_next != IDLE) begin
                r_scl_oen <= w_levels[1];
                r_sda_oen <= w_levels[0];
            end
            if (w_sample)
                r_dout <= bus.SdaIn;
        end
    end

    assign bus.CmdReady   = w_idle;
    assign bus.TimerStart = w_idle;
    assign bus.TimerStop  = w_stretch;
    assign bus.SclOen     = r_scl_oen;
    assign bus.SdaOen     = r_sda_oen;
    assign bus.Dout       = r_dout;
    assign bus.Done       = r_done;

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// tb_i2c_bit_ctrl: directed self-checking bench for i2c_bit_ctrl
//   Timer model: counter reloads on TimerStart, freezes on TimerStop, TimerOut while it reads 4,
//   giving phase A..D at samples 0-4, 5-9, 10-14, 15-19 after accept and Done at sample 20.
//   Bus: pull-ups, SclIn forced low by scl_hold, SdaIn follows slave_sda when released.
module tb_i2c_bit_ctrl;
    import i2c_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_hold = 1'b0;
    logic slave_sda = 1'b1;
    int   cnt = 0;
    int   checks = 0;
    int   errors = 0;

    logic s_scl [0:39];
    logic s_sda [0:39];
    logic s_done [0:39];
    logic s_tstop [0:39];
    logic s_ready [0:39];
    logic s_dout [0:39];

    i2c_bit_ctrl_if bus();

    i2c_bit_ctrl dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.TimerStart)
            cnt <= 0;
        else if (!bus.TimerStop)
            cnt <= (cnt == 4) ? 0 : cnt + 1;
    end

    assign bus.TimerOut = (cnt == 4);
    assign bus.SclIn    = bus.SclOen & ~scl_hold;
    assign bus.SdaIn    = bus.SdaOen & slave_sda;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic accept(input logic [1:0] c, input logic d);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.CmdReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.CmdReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: CmdReady=%b required 1", bus.CmdReady);
        end
        bus.Cmd      = c;
        bus.Din      = d;
        bus.CmdValid = 1'b1;
        @(posedge clk);
        #1;
        bus.CmdValid = 1'b0;
        bus.Din      = ~d;
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic d, input int hs, input int hl);
        accept(c, d);
        for (int s = 0; s < 40; s++) begin
            s_scl[s]   = bus.SclOen;
            s_sda[s]   = bus.SdaOen;
            s_done[s]  = bus.Done;
            s_tstop[s] = bus.TimerStop;
            s_ready[s] = bus.CmdReady;
            s_dout[s]  = bus.Dout;
            if (s == hs)
                scl_hold = 1'b1;
            if (s == hs + hl)
                scl_hold = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (bus.SclOen !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", bus.SclOen); end
        if (bus.SdaOen !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", bus.SdaOen); end
        if (bus.CmdReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.CmdReady); end
        if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        if (bus.Dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", bus.Dout); end
        if (bus.TimerStart !== 1'b1) begin errors++; $display("FAIL reset_tstart: got %b want 1", bus.TimerStart); end
        if (bus.TimerStop !== 1'b0) begin errors++; $display("FAIL reset_tstop: got %b want 0", bus.TimerStop); end
        rst = 1'b0;
    endtask

    task automatic check_phases(input string name, input logic [7:0] want);
        int ndone;
        logic [1:0] w;
        for (int p = 0; p < 4; p++) begin
            w = want[7 - 2*p -: 2];
            checks++;
            if ({s_scl[5*p+2], s_sda[5*p+2]} !== w) begin
                errors++;
                $display("FAIL %s_phase%0d: scl/sda got %b%b want %b", name, p, s_scl[5*p+2], s_sda[5*p+2], w);
            end
        end
        ndone = 0;
        for (int s = 0; s < 40; s++) ndone += int'(s_done[s]);
        checks += 2;
        if (s_done[20] !== 1'b1) begin errors++; $display("FAIL %s_done20: got %b want 1", name, s_done[20]); end
        if (ndone != 1) begin errors++; $display("FAIL %s_done_count: got %0d want 1", name, ndone); end
    endtask

    task automatic test_start_stop;
        run_cmd(CMD_START, 1'b0, 99, 0);
        check_phases("start", 8'b11_11_10_00);
        checks++;
        if ({s_scl[30], s_sda[30]} !== 2'b00) begin
            errors++;
            $display("FAIL start_idle_hold: got %b%b want 00", s_scl[30], s_sda[30]);
        end
        run_cmd(CMD_STOP, 1'b0, 99, 0);
        check_phases("stop", 8'b00_10_10_11);
        checks++;
        if ({s_scl[30], s_sda[30]} !== 2'b11) begin
            errors++;
            $display("FAIL stop_idle_hold: got %b%b want 11", s_scl[30], s_sda[30]);
        end
    endtask

    task automatic test_write;
        for (int b = 0; b < 2; b++) begin
            run_cmd(CMD_WRITE, b[0], 99, 0);
            for (int s = 0; s < 20; s++) begin
                checks += 2;
                if (s_sda[s] !== b[0]) begin
                    errors++;
                    $display("FAIL write%0d_sda_s%0d: got %b want %b", b, s, s_sda[s], b[0]);
                end
                if (s_scl[s] !== (s >= 5 && s < 15)) begin
                    errors++;
                    $display("FAIL write%0d_scl_s%0d: got %b want %b", b, s, s_scl[s], (s >= 5 && s < 15));
                end
            end
            checks++;
            if (s_done[20] !== 1'b1) begin errors++; $display("FAIL write%0d_done: got %b want 1", b, s_done[20]); end
        end
    endtask

    task automatic test_read;
        for (int b = 0; b < 2; b++) begin
            slave_sda = b[0];
            run_cmd(CMD_READ, 1'b0, 99, 0);
            slave_sda = 1'b1;
            for (int s = 0; s < 20; s++) begin
                checks++;
                if (s_sda[s] !== 1'b1) begin
                    errors++;
                    $display("FAIL read%0d_sda_released_s%0d: got %b want 1", b, s, s_sda[s]);
                end
            end
            checks += 3;
            if (s_done[20] !== 1'b1) begin errors++; $display("FAIL read%0d_done: got %b want 1", b, s_done[20]); end
            if (s_dout[20] !== b[0]) begin errors++; $display("FAIL read%0d_dout: got %b want %b", b, s_dout[20], b[0]); end
            if (s_scl[7] !== 1'b1) begin errors++; $display("FAIL read%0d_scl_b: got %b want 1", b, s_scl[7]); end
        end
    endtask

    task automatic test_busy;
        accept(CMD_WRITE, 1'b1);
        for (int s = 0; s < 25; s++) begin
            s_scl[s]   = bus.SclOen;
            s_done[s]  = bus.Done;
            s_ready[s] = bus.CmdReady;
            if (s == 3) begin
                bus.Cmd      = CMD_START;
                bus.CmdValid = 1'b1;
            end
            if (s == 19)
                bus.CmdValid = 1'b0;
            @(posedge clk);
            #1;
        end
        checks += 4;
        if (s_ready[10] !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", s_ready[10]); end
        if (s_done[20] !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", s_done[20]); end
        if (s_scl[22] !== 1'b0) begin errors++; $display("FAIL busy_no_queue_scl: got %b want 0", s_scl[22]); end
        if (s_ready[22] !== 1'b1) begin errors++; $display("FAIL busy_no_queue_ready: got %b want 1", s_ready[22]); end
    endtask

    task automatic test_stretch;
        int ndone;
        run_cmd(CMD_WRITE, 1'b1, 6, 12);
        ndone = 0;
        for (int s = 0; s < 40; s++) ndone += int'(s_done[s]);
        checks += 2;
        if (ndone != 1) begin errors++; $display("FAIL stretch_done_count: got %0d want 1", ndone); end
        if (s_scl[8] !== 1'b1) begin errors++; $display("FAIL stretch_scl_b: got %b want 1", s_scl[8]); end
`ifdef I2C_STRETCH_EN
        checks += 6;
        if (s_tstop[6] !== 1'b0) begin errors++; $display("FAIL stretch_tstop_s6: got %b want 0", s_tstop[6]); end
        if (s_tstop[7] !== 1'b1) begin errors++; $display("FAIL stretch_tstop_s7: got %b want 1", s_tstop[7]); end
        if (s_tstop[18] !== 1'b1) begin errors++; $display("FAIL stretch_tstop_s18: got %b want 1", s_tstop[18]); end
        if (s_tstop[19] !== 1'b0) begin errors++; $display("FAIL stretch_tstop_s19: got %b want 0", s_tstop[19]); end
        if (s_done[32] !== 1'b1) begin errors++; $display("FAIL stretch_done32: got %b want 1", s_done[32]); end
        if (s_scl[15] !== 1'b1) begin errors++; $display("FAIL stretch_scl_held: got %b want 1", s_scl[15]); end
`else
        for (int s = 0; s < 40; s++) begin
            checks++;
            if (s_tstop[s] !== 1'b0) begin
                errors++;
                $display("FAIL nostretch_tstop_s%0d: got %b want 0", s, s_tstop[s]);
            end
        end
        checks++;
        if (s_done[20] !== 1'b1) begin errors++; $display("FAIL nostretch_done20: got %b want 1", s_done[20]); end
`endif
    endtask

    task automatic test_reset_mid;
        int ndone;
        accept(CMD_WRITE, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (bus.SdaOen !== 1'b0) begin errors++; $display("FAIL mid_pre_sda: got %b want 0", bus.SdaOen); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks += 4;
        if (bus.SclOen !== 1'b1) begin errors++; $display("FAIL mid_rst_scl: got %b want 1", bus.SclOen); end
        if (bus.SdaOen !== 1'b1) begin errors++; $display("FAIL mid_rst_sda: got %b want 1", bus.SdaOen); end
        if (bus.Done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b want 0", bus.Done); end
        if (bus.CmdReady !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", bus.CmdReady); end
        ndone = 0;
        for (int s = 0; s < 25; s++) begin
            ndone += int'(bus.Done);
            @(posedge clk);
            #1;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", ndone); end
        run_cmd(CMD_START, 1'b0, 99, 0);
        check_phases("mid_start", 8'b11_11_10_00);
    endtask

    initial begin
        bus.Cmd      = CMD_START;
        bus.CmdValid = 1'b0;
        bus.Din      = 1'b0;
        test_reset;
        test_start_stop;
        test_write;
        test_read;
        test_busy;
        test_stretch;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_bit_ctrl.md
I2C_BIT_CTRL -- requirements
Module: i2c_bit_ctrl

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: Rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: Cmd  in  2  bit command: 0=START, 1=STOP, 2=WRITE, 3=READ.
REQ-004 SHALL have ports: CmdValid  in  1  command request; CmdReady  out  1  high only in IDLE.
REQ-005 SHALL have ports: Din  in  1  bit to write; Dout  out  1  last bit read.
REQ-006 SHALL have ports: Done  out  1  one-cycle pulse at command completion.
REQ-007 SHALL have ports: TimerOut  in  1  quarter-bit pulse from i2c_bit_timer; TimerStart  out  1  reload timer; TimerStop  out  1  hold timer.
REQ-008 SHALL have ports: SclIn/SdaIn  in  1  bus levels; SclOen/SdaOen  out  1  open-drain enables, 1=released (high), 0=drive low.

Function
REQ-009 SHALL accept a command on the edge where CmdValid=1 and CmdReady=1, and SHALL latch Cmd and Din.
REQ-010 SHALL enter phase A of the accepted command on the next cycle, with TimerStart=1 for that accept cycle only.
REQ-011 SHALL hold TimerStart=1 continuously in IDLE.
REQ-012 SHALL sequence every command through phases A,B,C,D, advancing one phase per TimerOut pulse.
REQ-013 SHALL drive START as (SCL,SDA) A:(1,1) B:(1,1) C:(1,0) D:(0,0).
REQ-014 SHALL drive STOP as (SCL,SDA) A:(0,0) B:(1,0) C:(1,0) D:(1,1).
REQ-015 SHALL drive WRITE as A:(0,Din) B:(1,Din) C:(1,Din) D:(0,Din).
REQ-016 SHALL drive READ as WRITE with SDA released (SdaOen=1) in all phases.
REQ-017 SHALL register SdaIn into Dout on the TimerOut that ends READ phase C.
REQ-018 SHALL pulse Done for exactly one cycle on the cycle after the TimerOut ending phase D, then return to IDLE.
REQ-019 SHALL ignore CmdValid while not in IDLE (CmdReady=0), with no queuing.
REQ-020 SHALL keep SclOen/SdaOen at their last values in IDLE after a command, except that after reset both are 1.
REQ-021 SHALL ignore a TimerOut coinciding with a command accept.
REQ-022 SHALL drive outputs from registers only (no combinational path from inputs to SclOen/SdaOen).

Reset
REQ-023 SHALL, with Rst=1 at an edge, go to IDLE with SclOen=1, SdaOen=1, Done=0, Dout=0, CmdReady=1, TimerStart=1, TimerStop=0.
REQ-024 SHALL abort any in-progress command on reset mid-operation and release the bus without asserting Done.
REQ-025 SHALL give Rst priority over CmdValid and TimerOut.

Configuration
REQ-026 SHALL implement clock stretching when macro I2C_STRETCH_EN is defined: in any phase B with SclOen=1 and SclIn=0, assert TimerStop=1, hold the phase, and ignore TimerOut until SclIn=1.
REQ-027 SHALL, when I2C_STRETCH_EN is undefined, tie TimerStop=0, ignore SclIn, and produce phase timing solely from TimerOut.

Structure
REQ-028 SHALL take command encodings (CMD_START/STOP/WRITE/READ) and the state enum (IDLE plus 16 command/phase states) from shared package i2c_pkg.
REQ-029 SHALL be one flat module with no sub-module; i2c_bit_timer is instantiated beside it at the parent level.

Verification (bench model pulses TimerOut every 5 cycles when TimerStop=0; bus pulled up, no slave unless stated)
REQ-030 SHALL cover: Rst=1 for 3 cycles -> SclOen=1, SdaOen=1, CmdReady=1, Done=0.
REQ-031 SHALL cover: START then STOP -> SDA falls while SCL=1 (START C), then rises while SCL=1 (STOP D); one Done per command, 20 cycles apart.
REQ-032 SHALL cover: WRITE Din=0 then WRITE Din=1 -> SdaOen constant over each bit's four phases, SCL high exactly in phases B and C.
REQ-033 SHALL cover: READ with slave driving SdaIn=0, then READ with SdaIn=1 -> Dout=0, then Dout=1, valid with Done.
REQ-034 SHALL cover (I2C_STRETCH_EN): WRITE with SclIn held 0 for 12 cycles in phase B -> TimerStop=1 for those cycles and Done delayed by 12 cycles versus the unstretched bit.
REQ-035 SHALL cover: Rst asserted in WRITE phase C -> next edge SclOen=1, SdaOen=1, no Done; a subsequent START completes normally.
